adder_tree_seq: RTL and testbench

Sequencer for the 8-operand, 7-bit `adder_tree` datapath. It collects up to eight operands from a valid/ready input stream and drives them, with a carry-in, onto the tree's `a`..`h`/`ci` inputs. It holds those inputs stable for a programmable settle window, because the tree is a multi-cycle combinational path. It then captures `s`/`co` and returns the result on a valid/ready output port. It sits between the operand producer and the result consumer, and it owns the only timing path into the tree.

---
 rtl/adder_tree_seq.sv | 136 +++++++++++++
 tb/tb_adder_tree_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/adder_tree_seq.sv
// Sequencer for the 8-operand adder_tree: collects a group of operands, holds them
// on the tree for a settle window, then captures and returns the sum with valid/ready.
module adder_tree_seq #(
  parameter int WIDTH  = 7,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             in_ci,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] op_c,
  output logic [WIDTH-1:0] op_d,
  output logic [WIDTH-1:0] op_e,
  output logic [WIDTH-1:0] op_f,
  output logic [WIDTH-1:0] op_g,
  output logic [WIDTH-1:0] op_h,
  output logic             tree_ci,
  input  logic [WIDTH-1:0] tree_s,
  input  logic             tree_co,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_co,
  output logic [3:0]       out_count
);

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_SETTLE,
    ST_HOLD
  } state_t;

  state_t                  state_q, state_d;
  logic [2:0]              cnt_q, cnt_d;
  logic [3:0]              timer_q, timer_d;
  logic [7:0][WIDTH-1:0]   slot_q, slot_d;
  logic                    tree_ci_q, tree_ci_d;
  logic [WIDTH-1:0]        out_sum_q, out_sum_d;
  logic                    out_co_q, out_co_d;
  logic [3:0]              out_count_q, out_count_d;
  logic                    out_valid_q, out_valid_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    timer_d     = timer_q;
    slot_d      = slot_q;
    tree_ci_d   = tree_ci_q;
    out_sum_d   = out_sum_q;
    out_co_d    = out_co_q;
    out_count_d = out_count_q;
    out_valid_d = out_valid_q;
    in_ready    = 1'b0;

    case (state_q)
      ST_COLLECT: begin
        in_ready = !rst;
        if (in_valid) begin
          slot_d[cnt_q] = in_data;
          cnt_d         = cnt_q + 3'd1;
          if (cnt_q == 3'd0) tree_ci_d = in_ci;
          if (cnt_q == 3'd7 || in_last) begin
            out_count_d = {1'b0, cnt_q} + 4'd1;
            timer_d     = 4'(SETTLE - 1);
            state_d     = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        if (timer_q != 4'd0) begin
          timer_d = timer_q - 4'd1;
        end else begin
          out_sum_d   = tree_s;
          out_co_d    = tree_co;
          out_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Clearing the slots here is what makes short groups add zeros next time.
        if (out_ready) begin
          out_valid_d = 1'b0;
          slot_d      = '0;
          tree_ci_d   = 1'b0;
          cnt_d       = 3'd0;
          state_d     = ST_COLLECT;
        end
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_COLLECT;
      cnt_q       <= 3'd0;
      timer_q     <= 4'd0;
      slot_q      <= '0;
      tree_ci_q   <= 1'b0;
      out_sum_q   <= '0;
      out_co_q    <= 1'b0;
      out_count_q <= 4'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      timer_q     <= timer_d;
      slot_q      <= slot_d;
      tree_ci_q   <= tree_ci_d;
      out_sum_q   <= out_sum_d;
      out_co_q    <= out_co_d;
      out_count_q <= out_count_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign op_a      = slot_q[0];
  assign op_b      = slot_q[1];
  assign op_c      = slot_q[2];
  assign op_d      = slot_q[3];
  assign op_e      = slot_q[4];
  assign op_f      = slot_q[5];
  assign op_g      = slot_q[6];
  assign op_h      = slot_q[7];
  assign tree_ci   = tree_ci_q;
  assign out_sum   = out_sum_q;
  assign out_co    = out_co_q;
  assign out_count = out_count_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_adder_tree_seq.sv
// Directed bench for adder_tree_seq with a behavioural 8-input adder tree closing the loop.
module tb_adder_tree_seq;

  localparam int WIDTH = 7;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             in_ci;
  logic [WIDTH-1:0] op_a, op_b, op_c, op_d, op_e, op_f, op_g, op_h;
  logic             tree_ci;
  logic [WIDTH-1:0] tree_s;
  logic             tree_co;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_co;
  logic [3:0]       out_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adder_tree_seq #(.WIDTH(WIDTH), .SETTLE(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_ci(in_ci),
    .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_d(op_d),
    .op_e(op_e), .op_f(op_f), .op_g(op_g), .op_h(op_h),
    .tree_ci(tree_ci), .tree_s(tree_s), .tree_co(tree_co),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_co(out_co), .out_count(out_count)
  );

  // Tree model: full sum of all operands plus carry-in; co flags overflow past WIDTH bits.
  logic [10:0] tree_total;
  assign tree_total = 11'(op_a) + 11'(op_b) + 11'(op_c) + 11'(op_d) + 11'(op_e)
                    + 11'(op_f) + 11'(op_g) + 11'(op_h) + 11'(tree_ci);
  assign tree_s  = tree_total[WIDTH-1:0];
  assign tree_co = (tree_total > 11'd127);

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Presents one beat at a negedge and returns at the negedge after it is accepted.
  task automatic applyStimulus(input logic [WIDTH-1:0] data, input logic last, input logic ci);
    int n;
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    in_ci    = ci;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("beat_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_ci    = 1'b0;
  endtask

  task automatic waitValid(input string tag, input int exp_latency);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, n, exp_latency);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    in_ci     = 1'b0;
    out_ready = 1'b1;

    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_out_sum", 32'(out_sum), 32'd0);
    checkOutput("rst_out_count", 32'(out_count), 32'd0);
    checkOutput("rst_op_a", 32'(op_a), 32'd0);
    checkOutput("rst_tree_ci", {31'd0, tree_ci}, 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    $display("[TB] full group");
    for (int i = 1; i <= 8; i++) applyStimulus(WIDTH'(i), 1'b0, 1'b0);
    checkOutput("full_op_h", 32'(op_h), 32'd8);
    checkOutput("full_in_ready_settle", {31'd0, in_ready}, 32'd0);
    waitValid("full_latency", 2);
    checkOutput("full_sum", 32'(out_sum), 32'd36);
    checkOutput("full_count", 32'(out_count), 32'd8);
    checkOutput("full_co", {31'd0, out_co}, 32'd0);
    @(negedge clk);
    checkOutput("full_valid_drop", {31'd0, out_valid}, 32'd0);
    checkOutput("full_turn_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("full_cleared_op_a", 32'(op_a), 32'd0);

    $display("[TB] short group with stall");
    applyStimulus(7'd10, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("stall_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("stall_op_b", 32'(op_b), 32'd0);
    applyStimulus(7'd20, 1'b0, 1'b0);
    applyStimulus(7'd30, 1'b1, 1'b0);
    checkOutput("short_op_c", 32'(op_c), 32'd30);
    checkOutput("short_op_d", 32'(op_d), 32'd0);
    checkOutput("short_op_h", 32'(op_h), 32'd0);
    checkOutput("short_tree_ci", {31'd0, tree_ci}, 32'd1);
    waitValid("short_latency", 2);
    checkOutput("short_sum", 32'(out_sum), 32'd61);
    checkOutput("short_count", 32'(out_count), 32'd3);
    @(negedge clk);

    $display("[TB] wrap group");
    applyStimulus(7'h7F, 1'b0, 1'b1);
    for (int i = 1; i < 8; i++) applyStimulus(7'h7F, 1'b0, 1'b0);
    waitValid("wrap_latency", 2);
    checkOutput("wrap_sum", 32'(out_sum), 32'd121);
    checkOutput("wrap_co", {31'd0, out_co}, 32'd1);
    checkOutput("wrap_count", 32'(out_count), 32'd8);
    @(negedge clk);

    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus(7'd3, 1'b0, 1'b0);
    applyStimulus(7'd4, 1'b1, 1'b0);
    waitValid("bp_latency", 2);
    in_valid = 1'b1;
    in_data  = 7'd99;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("bp_sum", 32'(out_sum), 32'd7);
      checkOutput("bp_count", 32'(out_count), 32'd2);
      checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
      checkOutput("bp_op_c", 32'(op_c), 32'd0);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("bp_release_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("bp_release_op_a", 32'(op_a), 32'd0);

    $display("[TB] reset mid-settle");
    applyStimulus(7'd1, 1'b0, 1'b1);
    applyStimulus(7'd2, 1'b0, 1'b0);
    applyStimulus(7'd3, 1'b0, 1'b0);
    applyStimulus(7'd4, 1'b1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("mid_rst_op_a", 32'(op_a), 32'd0);
    checkOutput("mid_rst_op_d", 32'(op_d), 32'd0);
    checkOutput("mid_rst_tree_ci", {31'd0, tree_ci}, 32'd0);
    checkOutput("mid_rst_sum", 32'(out_sum), 32'd0);
    checkOutput("mid_rst_count", 32'(out_count), 32'd0);
    checkOutput("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("mid_rst_no_valid", {31'd0, out_valid}, 32'd0);
    end
    applyStimulus(7'd5, 1'b0, 1'b0);
    applyStimulus(7'd6, 1'b1, 1'b0);
    checkOutput("after_rst_op_c", 32'(op_c), 32'd0);
    waitValid("after_rst_latency", 2);
    checkOutput("after_rst_sum", 32'(out_sum), 32'd11);
    checkOutput("after_rst_count", 32'(out_count), 32'd2);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
